// File: rtl/uart_rx_sequencer_pkg.sv
// Shared definitions for the UART receive sequencer: receiver mode constants,
// FSM state encodings and the number of BCLK strobes per 8N1 frame.
package uart_rx_sequencer_pkg;

   localparam logic IDLE_MODE = 1'b0;
   localparam logic BUSY_MODE = 1'b1;

   // 8 data bits plus the stop bit
   localparam int FRAME_BITS = 9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Sequencer-to-receiver signal bundle. FERR exists only when
// UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_sequencer_if;

   logic       ENABLE;
   logic       RX;
   logic       RX_SYNC;
   logic       STATE;
   logic       BCLK;
   logic       BREAK;
   logic [3:0] BIT_CNT;
`ifdef UART_RX_FRAME_ERR_EN
   logic       FERR;

   modport master (input ENABLE, RX, output RX_SYNC, STATE, BCLK, BREAK, BIT_CNT, FERR);
   modport slave  (output ENABLE, RX, input RX_SYNC, STATE, BCLK, BREAK, BIT_CNT, FERR);
`else
   modport master (input ENABLE, RX, output RX_SYNC, STATE, BCLK, BREAK, BIT_CNT);
   modport slave  (output ENABLE, RX, input RX_SYNC, STATE, BCLK, BREAK, BIT_CNT);
`endif

endinterface

// File: rtl/uart_rx_sequencer_sync.sv
// Two-flop synchroniser for the raw serial line; both flops reset to the
// idle-high line level so no false start is seen coming out of reset.
module uart_rx_sync (
   input  logic CLK,
   input  logic RESET,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         meta     <= 1'b1;
         sync_out <= 1'b1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_sequencer.sv
// Start-bit qualification and mid-bit BCLK generation for one 8N1 receive
// channel. Define UART_RX_FRAME_ERR_EN to add the FERR stop-bit check.
module uart_rx_sequencer
   import uart_rx_sequencer_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input logic                 CLK,
   input logic                 RESET,
   uart_rx_sequencer_if.master bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_sequencer: CLKS_PER_BIT must be at least 4");
   end

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic             rx_sync;
   logic             state_q;
   logic             bclk_q;
   logic             break_q;
   logic [3:0]       bit_cnt_q;
`ifdef UART_RX_FRAME_ERR_EN
   logic             ferr_q;
`endif

   uart_rx_sync u_rx_sync (
      .CLK      (CLK),
      .RESET    (RESET),
      .async_in (bus.RX),
      .sync_out (rx_sync)
   );

   // BCLK for the 9th (stop) bit is high while the FSM sits in S_DONE, so
   // BREAK and FERR are loaded there and appear one cycle later, never
   // overlapping a strobe. STATE stays busy through the BREAK cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_cnt_q <= '0;
         state_q   <= IDLE_MODE;
         bclk_q    <= 1'b0;
         break_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_q    <= 1'b0;
`endif
      end else begin
         bclk_q  <= 1'b0;
         break_q <= 1'b0;
         case (state)
            S_IDLE: begin
               baud_cnt  <= '0;
               bit_cnt_q <= '0;
               state_q   <= IDLE_MODE;
               if (bus.ENABLE && !rx_sync) begin
                  state <= S_START;
               end
            end
            S_START: begin
               if (baud_cnt == CNT_W'(HALF_BIT - 1)) begin
                  baud_cnt <= '0;
                  if (!rx_sync) begin
                     state   <= S_DATA;
                     state_q <= BUSY_MODE;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  baud_cnt  <= '0;
                  bclk_q    <= 1'b1;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                     state <= S_DONE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               break_q <= 1'b1;
               state   <= S_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
               ferr_q  <= ~rx_sync;
`endif
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.RX_SYNC = rx_sync;
   assign bus.STATE   = state_q;
   assign bus.BCLK    = bclk_q;
   assign bus.BREAK   = break_q;
   assign bus.BIT_CNT = bit_cnt_q;
`ifdef UART_RX_FRAME_ERR_EN
   assign bus.FERR    = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: drives 8N1 frames with random
// content and gaps, recovers bytes with a behavioural receiver, and checks timing.
module tb_uart_rx_sequencer;
   import uart_rx_sequencer_pkg::*;

   localparam int CLK_FREQ           = 1_600_000;
   localparam int BAUD_RATE          = 100_000;
   localparam int CLKS_PER_BIT       = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT           = CLKS_PER_BIT / 2;
   localparam int FIRST_BCLK_LATENCY = 2 + 1 + HALF_BIT + CLKS_PER_BIT;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   uart_rx_sequencer_if bus ();

   uart_rx_sequencer #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int fallCycle = 0;

   always @(posedge CLK) cycle <= cycle + 1;

   // Monitor plus behavioural receiver: samples RX_SYNC on each data-bit strobe,
   // delivers the byte on BREAK, and tallies protocol violations.
   int         bclkCount = 0;
   int         breakCount = 0;
   int         busyCount = 0;
   int         overlapCount = 0;
   int         stateErrCount = 0;
   int         spacingErrCount = 0;
   int         bclkIdleCount = 0;
   int         firstBclkCycle = 0;
   int         lastBclkCycle = 0;
   logic       prevBreak = 1'b0;
   logic [7:0] shiftReg = 8'h00;
   logic [7:0] rxQ[$];
`ifdef UART_RX_FRAME_ERR_EN
   logic       ferrQ[$];
`endif

   always @(negedge CLK) begin
      if (RESET) begin
         prevBreak <= 1'b0;
      end else begin
         if (bus.BCLK) begin
            bclkCount <= bclkCount + 1;
            if (bus.BIT_CNT == 4'd1) firstBclkCycle <= cycle;
            else if (cycle - lastBclkCycle != CLKS_PER_BIT) spacingErrCount <= spacingErrCount + 1;
            lastBclkCycle <= cycle;
            if (bus.STATE !== BUSY_MODE) bclkIdleCount <= bclkIdleCount + 1;
            if (bus.BIT_CNT >= 4'd1 && bus.BIT_CNT <= 4'd8)
               shiftReg[3'(bus.BIT_CNT - 4'd1)] <= bus.RX_SYNC;
         end
         if (bus.BREAK) begin
            breakCount <= breakCount + 1;
            rxQ.push_back(shiftReg);
`ifdef UART_RX_FRAME_ERR_EN
            ferrQ.push_back(bus.FERR);
`endif
            if (bus.BCLK) overlapCount <= overlapCount + 1;
            if (bus.STATE !== BUSY_MODE) stateErrCount <= stateErrCount + 1;
         end
         if (prevBreak && bus.STATE !== IDLE_MODE) stateErrCount <= stateErrCount + 1;
         if (bus.STATE === BUSY_MODE) busyCount <= busyCount + 1;
         prevBreak <= bus.BREAK;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Drives one frame, LSB first; optionally drops ENABLE or stops early at a given strobe.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                input int abortAtBit, input int dropEnableAtBit,
                                output bit aborted);
      logic [9:0] frame;
      frame     = {stopBit, data, 1'b0};
      fallCycle = cycle;
      aborted   = 1'b0;
      for (int c = 0; c < 10 * CLKS_PER_BIT; c++) begin
         bus.RX = frame[c / CLKS_PER_BIT];
         @(negedge CLK);
         if (dropEnableAtBit != 0 && bus.BCLK && int'(bus.BIT_CNT) == dropEnableAtBit)
            bus.ENABLE = 1'b0;
         if (abortAtBit != 0 && bus.BCLK && int'(bus.BIT_CNT) == abortAtBit) begin
            aborted = 1'b1;
            return;
         end
      end
      bus.RX = 1'b1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      bus.RX = 1'b0;
      tick(3);
      checks += 5;
      if (bus.RX_SYNC !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_sync: got %b expected 1", bus.RX_SYNC); end
      if (bus.STATE !== IDLE_MODE) begin errors++; $display("[TB] FAIL reset_state: got %b expected %b", bus.STATE, IDLE_MODE); end
      if (bus.BCLK !== 1'b0) begin errors++; $display("[TB] FAIL reset_bclk: got %b expected 0", bus.BCLK); end
      if (bus.BREAK !== 1'b0) begin errors++; $display("[TB] FAIL reset_break: got %b expected 0", bus.BREAK); end
      if (bus.BIT_CNT !== 4'd0) begin errors++; $display("[TB] FAIL reset_bit_cnt: got %0d expected 0", bus.BIT_CNT); end
`ifdef UART_RX_FRAME_ERR_EN
      checks++;
      if (bus.FERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", bus.FERR); end
`endif
      bus.RX = 1'b1;
      tick(2);
      RESET = 1'b0;
      tick(10);
      checks += 2;
      if (bus.STATE !== IDLE_MODE) begin errors++; $display("[TB] FAIL idle_state: got %b expected %b", bus.STATE, IDLE_MODE); end
      if (bus.RX_SYNC !== 1'b1) begin errors++; $display("[TB] FAIL idle_rx_sync: got %b expected 1", bus.RX_SYNC); end
   endtask

   task automatic test_single_frame();
      int b0, k0, q0, s0, o0, sp0, bi0, latency;
      bit ab;
      b0 = bclkCount; k0 = breakCount; q0 = rxQ.size(); s0 = stateErrCount;
      o0 = overlapCount; sp0 = spacingErrCount; bi0 = bclkIdleCount;
      applyStimulus(8'hA5, 1'b1, 0, 0, ab);
      tick(6);
      latency = firstBclkCycle - fallCycle;
      checks += 8;
      if (bclkCount - b0 != 9) begin errors++; $display("[TB] FAIL single_bclk_count: got %0d expected 9", bclkCount - b0); end
      if (spacingErrCount != sp0) begin errors++; $display("[TB] FAIL single_bclk_spacing: got %0d bad gaps expected 0", spacingErrCount - sp0); end
      if (breakCount - k0 != 1) begin errors++; $display("[TB] FAIL single_break_count: got %0d expected 1", breakCount - k0); end
      if (rxQ.size() != q0 + 1 || rxQ[q0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_rxdata: got %0d bytes expected A5", rxQ.size() - q0); end
      if (latency < FIRST_BCLK_LATENCY - 1 || latency > FIRST_BCLK_LATENCY + 1) begin
         errors++; $display("[TB] FAIL single_latency: got %0d expected %0d +-1", latency, FIRST_BCLK_LATENCY);
      end
      if (stateErrCount != s0) begin errors++; $display("[TB] FAIL single_state_around_break: got %0d bad cycles expected 0", stateErrCount - s0); end
      if (overlapCount != o0) begin errors++; $display("[TB] FAIL single_bclk_break_overlap: got %0d expected 0", overlapCount - o0); end
      if (bclkIdleCount != bi0) begin errors++; $display("[TB] FAIL single_bclk_while_idle: got %0d expected 0", bclkIdleCount - bi0); end
   endtask

   task automatic test_glitch();
      int b0, k0, u0, len;
      b0 = bclkCount; k0 = breakCount; u0 = busyCount;
      for (int g = 0; g < 5; g++) begin
         len = (g == 0) ? 4 : int'($urandom_range(1, 5));
         bus.RX = 1'b0;
         tick(len);
         bus.RX = 1'b1;
         tick(30);
      end
      checks += 3;
      if (bclkCount != b0) begin errors++; $display("[TB] FAIL glitch_bclk: got %0d expected 0", bclkCount - b0); end
      if (breakCount != k0) begin errors++; $display("[TB] FAIL glitch_break: got %0d expected 0", breakCount - k0); end
      if (busyCount != u0) begin errors++; $display("[TB] FAIL glitch_busy: got %0d busy cycles expected 0", busyCount - u0); end
   endtask

   task automatic test_back_to_back();
      int b0, k0, q0, sp0;
      bit ab;
      b0 = bclkCount; k0 = breakCount; q0 = rxQ.size(); sp0 = spacingErrCount;
      applyStimulus(8'h00, 1'b1, 0, 0, ab);
      applyStimulus(8'hFF, 1'b1, 0, 0, ab);
      tick(20);
      checks += 4;
      if (bclkCount - b0 != 18) begin errors++; $display("[TB] FAIL b2b_bclk_count: got %0d expected 18", bclkCount - b0); end
      if (breakCount - k0 != 2) begin errors++; $display("[TB] FAIL b2b_break_count: got %0d expected 2", breakCount - k0); end
      if (rxQ.size() != q0 + 2 || rxQ[q0] !== 8'h00 || rxQ[q0+1] !== 8'hFF) begin
         errors++; $display("[TB] FAIL b2b_rxdata: got %0d bytes expected 00 then FF", rxQ.size() - q0);
      end
      if (spacingErrCount != sp0) begin errors++; $display("[TB] FAIL b2b_bclk_spacing: got %0d bad gaps expected 0", spacingErrCount - sp0); end
   endtask

   task automatic test_reset_mid_frame();
      int b0, k0, q0;
      bit ab;
      b0 = bclkCount; k0 = breakCount;
      applyStimulus(8'hC3, 1'b1, 4, 0, ab);
      #2 RESET = 1'b1;
      #1;
      checks += 6;
      if (!ab) begin errors++; $display("[TB] FAIL rst_mid_reached_bclk4: got %0d strobes expected 4", bclkCount - b0); end
      if (bus.BCLK !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_bclk: got %b expected 0", bus.BCLK); end
      if (bus.STATE !== IDLE_MODE) begin errors++; $display("[TB] FAIL rst_mid_state: got %b expected %b", bus.STATE, IDLE_MODE); end
      if (bus.BIT_CNT !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_bit_cnt: got %0d expected 0", bus.BIT_CNT); end
      if (bus.RX_SYNC !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_rx_sync: got %b expected 1", bus.RX_SYNC); end
      if (bus.BREAK !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_break: got %b expected 0", bus.BREAK); end
      bus.RX = 1'b1;
      tick(3);
      RESET = 1'b0;
      tick(200);
      checks++;
      if (breakCount != k0) begin errors++; $display("[TB] FAIL rst_mid_no_break: got %0d expected 0", breakCount - k0); end
      q0 = rxQ.size(); k0 = breakCount;
      applyStimulus(8'h3C, 1'b1, 0, 0, ab);
      tick(6);
      checks += 2;
      if (breakCount - k0 != 1) begin errors++; $display("[TB] FAIL rst_mid_next_break: got %0d expected 1", breakCount - k0); end
      if (rxQ.size() != q0 + 1 || rxQ[q0] !== 8'h3C) begin errors++; $display("[TB] FAIL rst_mid_next_rxdata: got %0d bytes expected 3C", rxQ.size() - q0); end
   endtask

   task automatic test_enable();
      int b0, k0, u0, q0;
      bit ab;
      logic [7:0] data;
      b0 = bclkCount; k0 = breakCount; u0 = busyCount;
      bus.ENABLE = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.RX = 1'($urandom_range(0, 1));
         tick(int'($urandom_range(1, 20)));
      end
      bus.RX = 1'b1;
      tick(10);
      checks += 3;
      if (bclkCount != b0) begin errors++; $display("[TB] FAIL disabled_bclk: got %0d expected 0", bclkCount - b0); end
      if (breakCount != k0) begin errors++; $display("[TB] FAIL disabled_break: got %0d expected 0", breakCount - k0); end
      if (busyCount != u0) begin errors++; $display("[TB] FAIL disabled_busy: got %0d busy cycles expected 0", busyCount - u0); end
      bus.ENABLE = 1'b1;
      tick(2);
      b0 = bclkCount; k0 = breakCount; q0 = rxQ.size();
      data = 8'($urandom);
      applyStimulus(data, 1'b1, 0, 2, ab);
      tick(6);
      bus.ENABLE = 1'b1;
      checks += 3;
      if (bclkCount - b0 != 9) begin errors++; $display("[TB] FAIL enable_drop_bclk: got %0d expected 9", bclkCount - b0); end
      if (breakCount - k0 != 1) begin errors++; $display("[TB] FAIL enable_drop_break: got %0d expected 1", breakCount - k0); end
      if (rxQ.size() != q0 + 1 || rxQ[q0] !== data) begin errors++; $display("[TB] FAIL enable_drop_rxdata: got %0d bytes expected %h", rxQ.size() - q0, data); end
   endtask

   task automatic test_stop_low();
      int k0, q0;
      bit ab;
      logic [7:0] data;
      k0 = breakCount; q0 = rxQ.size();
      applyStimulus(8'h55, 1'b0, 0, 0, ab);
      tick(30);
      checks += 2;
      if (breakCount - k0 != 1) begin errors++; $display("[TB] FAIL stop_low_break: got %0d expected 1", breakCount - k0); end
      if (rxQ.size() != q0 + 1 || rxQ[q0] !== 8'h55) begin errors++; $display("[TB] FAIL stop_low_rxdata: got %0d bytes expected 55", rxQ.size() - q0); end
`ifdef UART_RX_FRAME_ERR_EN
      checks += 2;
      if (ferrQ.size() != q0 + 1 || ferrQ[q0] !== 1'b1) begin errors++; $display("[TB] FAIL ferr_set: got %0d entries expected FERR=1", ferrQ.size() - q0); end
      if (bus.FERR !== 1'b1) begin errors++; $display("[TB] FAIL ferr_hold: got %b expected 1", bus.FERR); end
`endif
      data = 8'($urandom);
      q0 = rxQ.size();
      applyStimulus(data, 1'b1, 0, 0, ab);
      tick(6);
      checks++;
      if (rxQ.size() != q0 + 1 || rxQ[q0] !== data) begin errors++; $display("[TB] FAIL stop_ok_rxdata: got %0d bytes expected %h", rxQ.size() - q0, data); end
`ifdef UART_RX_FRAME_ERR_EN
      checks++;
      if (ferrQ.size() != q0 + 1 || ferrQ[q0] !== 1'b0) begin errors++; $display("[TB] FAIL ferr_clear: got %0d entries expected FERR=0", ferrQ.size() - q0); end
`endif
   endtask

   task automatic test_random_frames();
      logic [7:0] sent[$];
      int b0, k0, q0, sp0;
      bit ab;
      b0 = bclkCount; k0 = breakCount; q0 = rxQ.size(); sp0 = spacingErrCount;
      for (int i = 0; i < 8; i++) begin
         sent.push_back(8'($urandom));
         applyStimulus(sent[i], 1'b1, 0, 0, ab);
         tick(int'($urandom_range(0, 24)));
      end
      tick(10);
      checks += 3;
      if (bclkCount - b0 != 9 * sent.size()) begin errors++; $display("[TB] FAIL rand_bclk_count: got %0d expected %0d", bclkCount - b0, 9 * sent.size()); end
      if (breakCount - k0 != sent.size()) begin errors++; $display("[TB] FAIL rand_break_count: got %0d expected %0d", breakCount - k0, sent.size()); end
      if (spacingErrCount != sp0) begin errors++; $display("[TB] FAIL rand_bclk_spacing: got %0d bad gaps expected 0", spacingErrCount - sp0); end
      for (int i = 0; i < sent.size(); i++) begin
         checks++;
         if (rxQ.size() <= q0 + i) begin
            errors++; $display("[TB] FAIL rand_rxdata_%0d: got no byte expected %h", i, sent[i]);
         end else if (rxQ[q0+i] !== sent[i]) begin
            errors++; $display("[TB] FAIL rand_rxdata_%0d: got %h expected %h", i, rxQ[q0+i], sent[i]);
         end
      end
   endtask

   initial begin
      bus.RX     = 1'b1;
      bus.ENABLE = 1'b1;
      RESET      = 1'b1;
      test_reset();
      test_single_frame();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_enable();
      test_stop_low();
      test_random_frames();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
